// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding, SDRAM geometry
// defaults and a constant log2 helper used to size slot indices.
package sdram_pkg;

  localparam int unsigned SD_BW = 2;
  localparam int unsigned SD_RW = 13;
  localparam int unsigned SD_CW = 9;
  localparam int unsigned SD_AW = SD_BW + SD_RW + SD_CW;
  localparam int unsigned SD_BL = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } arb_state_e;

  // Ceiling log2, never less than 1 so single-entry indices stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Command bus between the port arbiter (master) and sdram_ctrl (slave).
//  sd_wr/sd_rd       : burst command, held for the whole burst
//  sd_baddr/raddr/caddr : bank/row/column of the current burst
//  sd_wdone/sd_rdone : one-cycle burst-finished pulses from the controller
interface sdram_port_arbiter_if
  import sdram_pkg::*;
#(
  parameter int unsigned BW = SD_BW,
  parameter int unsigned RW = SD_RW,
  parameter int unsigned CW = SD_CW
);

  logic          sd_wr;
  logic          sd_rd;
  logic [BW-1:0] sd_baddr;
  logic [RW-1:0] sd_raddr;
  logic [CW-1:0] sd_caddr;
  logic          sd_wdone;
  logic          sd_rdone;

  modport master (
    output sd_wr, sd_rd, sd_baddr, sd_raddr, sd_caddr,
    input  sd_wdone, sd_rdone
  );

  modport slave (
    input  sd_wr, sd_rd, sd_baddr, sd_raddr, sd_caddr,
    output sd_wdone, sd_rdone
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N requestors.
//  req       : request vector
//  advance   : move the rotating pointer past the current winner
//  gnt_c     : one-hot grant (combinational)
//  gnt_idx_c : index of the granted requestor (combinational)
//  gnt_vld_c : any request granted (combinational)
module rr_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] gnt_idx_c,
  output logic          gnt_vld_c
);

  logic [IW-1:0] ptr_q, ptr_d;

  // First request at or after the pointer, searching cyclically.
  always_comb begin
    int unsigned   slot;
    logic [IW-1:0] slot_idx;
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    slot      = 0;
    slot_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      slot = 32'(ptr_q) + k;
      if (slot >= N) slot = slot - N;
      slot_idx = IW'(slot);
      if (!gnt_vld_c && req[slot_idx]) begin
        gnt_vld_c       = 1'b1;
        gnt_idx_c       = slot_idx;
        gnt_c[slot_idx] = 1'b1;
      end
    end
  end

  // Pointer lands just past the winner so it has lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && gnt_vld_c) begin
      ptr_d = (gnt_idx_c == IW'(N - 1)) ? '0 : gnt_idx_c + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-channel front end for sdram_ctrl. NCH write and NCH read channels each
// own a wrap-around address window; one eligible channel is granted per burst
// by round-robin (slots 0..NCH-1 write, NCH..2NCH-1 read).
//  clk_100m, rst       : clock, async active-high reset
//  wr_level/rd_level   : per-channel FIFO used words
//  wr_base/rd_base     : per-channel window start
//  wr_max/rd_max       : per-channel window end (exclusive)
//  wr_load/rd_load     : per-channel pointer reload, also arms the channel
//  bus                 : SDRAM command bus (master side)
//  wr_sel/rd_sel       : one-hot owner of the current burst (FIFO steering)
//  busy                : FSM not idle
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned AW        = SD_AW,
  parameter int unsigned BW        = SD_BW,
  parameter int unsigned RW        = SD_RW,
  parameter int unsigned CW        = SD_CW,
  parameter int unsigned BL        = SD_BL,
  parameter int unsigned LVL_W     = 8,
  parameter int unsigned RD_THRESH = 128
) (
  input  logic                 clk_100m,
  input  logic                 rst,
  input  logic [NCH*LVL_W-1:0] wr_level,
  input  logic [NCH*AW-1:0]    wr_base,
  input  logic [NCH*AW-1:0]    wr_max,
  input  logic [NCH-1:0]       wr_load,
  input  logic [NCH*LVL_W-1:0] rd_level,
  input  logic [NCH*AW-1:0]    rd_base,
  input  logic [NCH*AW-1:0]    rd_max,
  input  logic [NCH-1:0]       rd_load,
  sdram_port_arbiter_if.master bus,
  output logic [NCH-1:0]       wr_sel,
  output logic [NCH-1:0]       rd_sel,
  output logic                 busy
);

  localparam int unsigned NS = 2 * NCH;
  localparam int unsigned IW = clog2(NS);

  arb_state_e     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [NCH-1:0] wr_sel_q, wr_sel_d;
  logic [NCH-1:0] rd_sel_q, rd_sel_d;
  logic           sd_wr_q, sd_wr_d;
  logic           sd_rd_q, sd_rd_d;
  logic           busy_q, busy_d;

  logic [NCH-1:0] wr_elig, rd_elig;
  logic [AW-1:0]  slot_ptr [NS];
  logic           wr_done, rd_done;

  logic [NS-1:0]  req;
  logic [NS-1:0]  gnt_c;
  logic [IW-1:0]  gnt_idx_c;
  logic           gnt_vld_c;

  // Done pulses only count in the matching burst state.
  assign wr_done = (state_q == ST_WR) && bus.sd_wdone;
  assign rd_done = (state_q == ST_RD) && bus.sd_rdone;

  // Per-channel pointer and armed flag; load wins over the done increment.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [LVL_W-1:0] wl, rl;
    logic [AW-1:0]    wb, wm, rb, rm;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic             warm_q, warm_d, rarm_q, rarm_d;

    assign wl = wr_level[i*LVL_W +: LVL_W];
    assign rl = rd_level[i*LVL_W +: LVL_W];
    assign wb = wr_base[i*AW +: AW];
    assign wm = wr_max[i*AW +: AW];
    assign rb = rd_base[i*AW +: AW];
    assign rm = rd_max[i*AW +: AW];

    assign wr_elig[i] = warm_q && !wr_load[i] && (32'(wl) >= BL);
    assign rd_elig[i] = rarm_q && !rd_load[i] && (32'(rl) < RD_THRESH);

    assign slot_ptr[i]       = wptr_q;
    assign slot_ptr[NCH + i] = rptr_q;

    always_comb begin
      wptr_d = wptr_q;
      warm_d = warm_q;
      if (wr_load[i]) begin
        wptr_d = wb;
        warm_d = 1'b1;
      end else if (wr_done && wr_sel_q[i]) begin
        wptr_d = (wptr_q == wm - AW'(BL)) ? wb : wptr_q + AW'(BL);
      end
    end

    always_comb begin
      rptr_d = rptr_q;
      rarm_d = rarm_q;
      if (rd_load[i]) begin
        rptr_d = rb;
        rarm_d = 1'b1;
      end else if (rd_done && rd_sel_q[i]) begin
        rptr_d = (rptr_q == rm - AW'(BL)) ? rb : rptr_q + AW'(BL);
      end
    end

    always_ff @(posedge clk_100m or posedge rst) begin
      if (rst) begin
        wptr_q <= '0;
        warm_q <= 1'b0;
        rptr_q <= '0;
        rarm_q <= 1'b0;
      end else begin
        wptr_q <= wptr_d;
        warm_q <= warm_d;
        rptr_q <= rptr_d;
        rarm_q <= rarm_d;
      end
    end
  end

  // Arbitration only happens in IDLE, so the pointer advances once per grant.
  assign req = (state_q == ST_IDLE) ? {rd_elig, wr_elig} : '0;

  rr_arbiter #(.N(NS)) u_rr (
    .clk       (clk_100m),
    .rst       (rst),
    .req       (req),
    .advance   (gnt_vld_c),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (gnt_vld_c)
  );

  // Next state and registered command outputs.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld_c) begin
          state_d  = (32'(gnt_idx_c) < NCH) ? ST_WR : ST_RD;
          addr_d   = slot_ptr[gnt_idx_c];
          wr_sel_d = gnt_c[NCH-1:0];
          rd_sel_d = gnt_c[NS-1:NCH];
        end
      end
      ST_WR: begin
        if (bus.sd_wdone) begin
          state_d  = ST_IDLE;
          addr_d   = '0;
          wr_sel_d = '0;
        end
      end
      ST_RD: begin
        if (bus.sd_rdone) begin
          state_d  = ST_IDLE;
          addr_d   = '0;
          rd_sel_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        addr_d   = '0;
        wr_sel_d = '0;
        rd_sel_d = '0;
      end
    endcase
    sd_wr_d = (state_d == ST_WR);
    sd_rd_d = (state_d == ST_RD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wr_sel_q <= '0;
      rd_sel_q <= '0;
      sd_wr_q  <= 1'b0;
      sd_rd_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      sd_wr_q  <= sd_wr_d;
      sd_rd_q  <= sd_rd_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sd_wr    = sd_wr_q;
  assign bus.sd_rd    = sd_rd_q;
  assign bus.sd_baddr = addr_q[AW-1 -: BW];
  assign bus.sd_raddr = addr_q[CW +: RW];
  assign bus.sd_caddr = addr_q[CW-1:0];
  assign wr_sel       = wr_sel_q;
  assign rd_sel       = rd_sel_q;
  assign busy         = busy_q;

endmodule
